// File: rtl/eth_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_frame_ctrl
// Purpose  : RX admission controller between the GMII receiver stream and the
//            drop-capable RX packet FIFO. Tracks frames, filters on DA,
//            length and receive errors, flags commit/drop on the final beat
//            and keeps saturating per-class frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_frame_ctrl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             rx_enable,
  input  logic             promisc,
  input  logic             accept_bcast,
  input  logic             accept_mcast,
  input  logic [47:0]      mac_addr,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  output logic [CNT_W-1:0] cnt_filt
);

  localparam logic [15:0]      c_min_len   = 16'(MIN_LEN);
  localparam logic [15:0]      c_giant_len = 16'(MAX_LEN + 1);
  localparam logic [15:0]      c_da_len    = 16'd6;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bcnt_q, bcnt_d;      // bytes accepted so far in this frame
  logic        err_q, err_d;        // sticky receive error
  logic        uc_q, uc_d;          // DA still matches station address
  logic        bc_q, bc_d;          // DA still all-ones
  logic        mc_q, mc_d;          // DA group bit

  logic [7:0]  mdata_q, mdata_d;
  logic        mvalid_q, mvalid_d;
  logic        mlast_q, mlast_d;
  logic        muser_q, muser_d;

  logic [CNT_W-1:0] cnt_ok_q, cnt_err_q, cnt_filt_q;

  logic        w_sof;
  logic        w_take;
  logic [15:0] w_idx;
  logic [15:0] w_len;
  logic        w_in_da;
  logic [7:0]  w_mac_byte;
  logic        w_uc, w_bc, w_mc, w_err;
  logic        w_accept, w_bad, w_giant;
  logic        w_inc_ok, w_inc_err, w_inc_filt;

  // Per-beat evaluation: frame position, DA tracking including this beat, verdict
  always_comb begin
    w_mac_byte = 8'h00;
    w_sof      = (state_q == ST_IDLE);
    w_take     = s_axis_tvalid && ((state_q == ST_ACTIVE) || (w_sof && rx_enable));
    w_idx      = w_sof ? 16'd0 : bcnt_q;
    w_len      = w_sof ? 16'd1 : ((bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1);
    w_in_da    = (w_idx < c_da_len);
    case (w_idx[2:0])
      3'd0:    w_mac_byte = mac_addr[47:40];
      3'd1:    w_mac_byte = mac_addr[39:32];
      3'd2:    w_mac_byte = mac_addr[31:24];
      3'd3:    w_mac_byte = mac_addr[23:16];
      3'd4:    w_mac_byte = mac_addr[15:8];
      default: w_mac_byte = mac_addr[7:0];
    endcase
    // A new frame restarts every flag from this beat rather than the stale registers
    w_uc     = (w_sof ? 1'b1 : uc_q) & (!w_in_da || (s_axis_tdata == w_mac_byte));
    w_bc     = (w_sof ? 1'b1 : bc_q) & (!w_in_da || (s_axis_tdata == 8'hFF));
    w_mc     = w_sof ? s_axis_tdata[0] : mc_q;
    w_err    = (w_sof ? 1'b0 : err_q) | s_axis_tuser;
    w_accept = promisc | w_uc | (accept_bcast & w_bc) | (accept_mcast & w_mc & ~w_bc);
    // Runts include frames too short to carry a full DA, so DA flags never matter there
    w_bad    = w_err | (w_len < c_min_len);
    w_giant  = !s_axis_tlast && (w_len == c_giant_len);
  end

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, forwarded beat and counter events
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    err_d      = err_q;
    uc_d       = uc_q;
    bc_d       = bc_q;
    mc_d       = mc_q;
    mdata_d    = mdata_q;
    mvalid_d   = 1'b0;
    mlast_d    = 1'b0;
    muser_d    = 1'b0;
    w_inc_ok   = 1'b0;
    w_inc_err  = 1'b0;
    w_inc_filt = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (w_take) begin
          mvalid_d = 1'b1;
          mdata_d  = s_axis_tdata;
          bcnt_d   = w_len;
          err_d    = w_err;
          uc_d     = w_uc;
          bc_d     = w_bc;
          mc_d     = w_mc;
          if (s_axis_tlast) begin
            state_d    = ST_IDLE;
            mlast_d    = 1'b1;
            muser_d    = w_bad | ~w_accept;
            w_inc_err  = w_bad;
            w_inc_filt = ~w_bad & ~w_accept;
            w_inc_ok   = ~w_bad & w_accept;
          end else if (w_giant) begin
            // Close the frame early towards the FIFO and swallow the rest
            state_d   = ST_DISCARD;
            mlast_d   = 1'b1;
            muser_d   = 1'b1;
            w_inc_err = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else if (s_axis_tvalid && (state_q == ST_IDLE)) begin
          // Receiver disabled at frame start: count once now, forward nothing
          w_inc_filt = 1'b1;
          state_d    = s_axis_tlast ? ST_IDLE : ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame tracking flags and registered output beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q   <= 16'd0;
      err_q    <= 1'b0;
      uc_q     <= 1'b0;
      bc_q     <= 1'b0;
      mc_q     <= 1'b0;
      mdata_q  <= 8'h00;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      muser_q  <= 1'b0;
    end else begin
      bcnt_q   <= bcnt_d;
      err_q    <= err_d;
      uc_q     <= uc_d;
      bc_q     <= bc_d;
      mc_q     <= mc_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      muser_q  <= muser_d;
    end
  end

  // Statistics counters: clear beats a same-cycle increment, each saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ok_q   <= '0;
      cnt_err_q  <= '0;
      cnt_filt_q <= '0;
    end else if (cnt_clear) begin
      cnt_ok_q   <= '0;
      cnt_err_q  <= '0;
      cnt_filt_q <= '0;
    end else begin
      if (w_inc_ok && (cnt_ok_q != '1)) begin
        cnt_ok_q <= cnt_ok_q + c_cnt_one;
      end
      if (w_inc_err && (cnt_err_q != '1)) begin
        cnt_err_q <= cnt_err_q + c_cnt_one;
      end
      if (w_inc_filt && (cnt_filt_q != '1)) begin
        cnt_filt_q <= cnt_filt_q + c_cnt_one;
      end
    end
  end

  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvalid_q;
  assign m_axis_tlast  = mlast_q;
  assign m_axis_tuser  = muser_q;
  assign cnt_ok        = cnt_ok_q;
  assign cnt_err       = cnt_err_q;
  assign cnt_filt      = cnt_filt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_frame_ctrl
// Purpose  : Self-checking bench for eth_rx_frame_ctrl. Each frame's fate is
//            worked out from its bytes as a whole, turned into expected
//            output beats and counter events, and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_ctrl;

  localparam int          MIN_LEN  = 64;
  localparam int          MAX_LEN  = 1522;
  localparam int          CNT_W    = 2;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam logic [47:0] MAC      = 48'h02_00_00_00_00_01;
  localparam int          CLS_NONE = 0;
  localparam int          CLS_OK   = 1;
  localparam int          CLS_ERR  = 2;
  localparam int          CLS_FILT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       s_axis_tdata = 8'h00;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tuser = 1'b0;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic             rx_enable = 1'b1;
  logic             promisc = 1'b0;
  logic             accept_bcast = 1'b0;
  logic             accept_mcast = 1'b0;
  logic [47:0]      mac_addr = MAC;
  logic             cnt_clear = 1'b0;
  logic [CNT_W-1:0] cnt_ok, cnt_err, cnt_filt;

  eth_rx_frame_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .rx_enable(rx_enable), .promisc(promisc),
    .accept_bcast(accept_bcast), .accept_mcast(accept_mcast),
    .mac_addr(mac_addr), .cnt_clear(cnt_clear),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err), .cnt_filt(cnt_filt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectation for the cycle after the current input (pending) and the one on the outputs now
  logic       pe_v = 1'b0, pe_l = 1'b0, pe_u = 1'b0, pe_clr = 1'b0;
  logic [7:0] pe_d = 8'h00;
  int         pe_cls = 0;
  logic       ce_v = 1'b0, ce_l = 1'b0, ce_u = 1'b0;
  logic [7:0] ce_d = 8'h00;
  int         m_ok = 0, m_err = 0, m_filt = 0;

  int         out_beats = 0;
  logic       last_user = 1'b0;

  logic [7:0] fb[$];
  logic       fu[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Model advance on each clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_v <= 1'b0; ce_l <= 1'b0; ce_u <= 1'b0; ce_d <= 8'h00;
      m_ok <= 0; m_err <= 0; m_filt <= 0;
    end else begin
      ce_v <= pe_v; ce_l <= pe_l; ce_u <= pe_u; ce_d <= pe_d;
      if (pe_clr) begin
        m_ok <= 0; m_err <= 0; m_filt <= 0;
      end else begin
        case (pe_cls)
          CLS_OK:   m_ok   <= sat_inc(m_ok);
          CLS_ERR:  m_err  <= sat_inc(m_err);
          CLS_FILT: m_filt <= sat_inc(m_filt);
          default: ;
        endcase
      end
    end
  end

  // Compare and beat monitor, away from the active edge
  always @(negedge clk) begin
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(ce_v));
    if (ce_v) begin
      chk("m_tdata", 64'(m_axis_tdata), 64'(ce_d));
      chk("m_tlast", 64'(m_axis_tlast), 64'(ce_l));
      if (ce_l) chk("m_tuser", 64'(m_axis_tuser), 64'(ce_u));
    end
    chk("cnt_ok", 64'(cnt_ok), 64'(m_ok));
    chk("cnt_err", 64'(cnt_err), 64'(m_err));
    chk("cnt_filt", 64'(cnt_filt), 64'(m_filt));
    if (m_axis_tvalid === 1'b1) begin
      out_beats++;
      if (m_axis_tlast) last_user = m_axis_tuser;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic u,
                       input logic ev, input logic [7:0] ed, input logic el, input logic eu,
                       input int cls, input logic clr);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u;
    cnt_clear = clr;
    pe_v = ev; pe_d = ed; pe_l = el; pe_u = eu; pe_cls = cls; pe_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Invalid cycle with garbage on the data lines
  task automatic idle(input logic clr);
    drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, CLS_NONE, clr);
  endtask

  task automatic build(input logic [47:0] da, input int len);
    fb.delete();
    fu.delete();
    for (int i = 0; i < len; i++) begin
      fb.push_back(i < 6 ? da[47-8*i -: 8] : 8'($urandom));
      fu.push_back(1'b0);
    end
  endtask

  // Decide the frame's fate from its contents, then play it beat by beat
  task automatic send_frame(input bit gaps, input bit toggle_en, input bit clr_last, input int stop_at);
    int          len;
    bit          en, anyerr, uc, bc, mc, acc, giant, last_u;
    int          n_out, cls, ev;
    logic [47:0] st;
    len = fb.size();
    en = rx_enable;
    st = mac_addr;
    anyerr = 1'b0; uc = 1'b1; bc = 1'b1;
    foreach (fu[i]) anyerr |= fu[i];
    mc = fb[0][0];
    for (int i = 0; i < 6 && i < len; i++) begin
      uc &= (fb[i] == st[47-8*i -: 8]);
      bc &= (fb[i] == 8'hFF);
    end
    acc   = promisc | uc | (accept_bcast & bc) | (accept_mcast & mc & !bc);
    giant = (len > MAX_LEN + 1);
    if (!en) begin
      n_out = 0; cls = CLS_FILT;
    end else if (giant) begin
      n_out = MAX_LEN + 1; cls = CLS_ERR;
    end else begin
      n_out = len;
      cls = (anyerr || len < MIN_LEN) ? CLS_ERR : (!acc ? CLS_FILT : CLS_OK);
    end
    last_u = (cls != CLS_OK);
    for (int i = 0; i < len; i++) begin
      if (stop_at >= 0 && i >= stop_at) break;
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) idle(1'b0);
      if (toggle_en && i == 10) rx_enable = ~rx_enable;
      ev = ((en && i == n_out - 1) || (!en && i == 0)) ? cls : CLS_NONE;
      drive(1'b1, fb[i], i == len - 1, fu[i], i < n_out, fb[i], i == n_out - 1, last_u,
            ev, clr_last && (i == len - 1));
    end
  endtask

  task automatic clear_cnt();
    idle(1'b1);
    idle(1'b0);
  endtask

  task automatic settle();
    idle(1'b0);
    idle(1'b0);
  endtask

  int          b0;
  logic [47:0] da;
  logic [7:0]  rest_b[$];
  logic        rest_u[$];

  initial begin
    #1 rst = 1'b1;
    #20 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_cnt_ok", 64'(cnt_ok), 64'd0);

    // Unicast good frame
    b0 = out_beats; build(MAC, 64); send_frame(0, 0, 0, -1); settle();
    chk("uc_beats", 64'(out_beats - b0), 64'd64);
    chk("uc_last_user", 64'(last_user), 64'd0);
    chk("uc_cnt_ok", 64'(cnt_ok), 64'd1);

    // Broadcast rejected, then accepted
    clear_cnt();
    b0 = out_beats; build(48'hFFFF_FFFF_FFFF, 100); send_frame(1, 0, 0, -1); settle();
    chk("bc_beats", 64'(out_beats - b0), 64'd100);
    chk("bc_rej_user", 64'(last_user), 64'd1);
    chk("bc_cnt_filt", 64'(cnt_filt), 64'd1);
    accept_bcast = 1'b1;
    build(48'hFFFF_FFFF_FFFF, 100); send_frame(0, 0, 0, -1); settle();
    chk("bc_acc_user", 64'(last_user), 64'd0);
    chk("bc_cnt_ok", 64'(cnt_ok), 64'd1);
    accept_bcast = 1'b0;

    // Receive error mid-frame, then a runt
    clear_cnt();
    build(MAC, 80); fu[39] = 1'b1; send_frame(0, 0, 0, -1); settle();
    chk("err_user", 64'(last_user), 64'd1);
    chk("err_cnt", 64'(cnt_err), 64'd1);
    build(MAC, 60); send_frame(0, 0, 0, -1); settle();
    chk("runt_user", 64'(last_user), 64'd1);
    chk("runt_cnt", 64'(cnt_err), 64'd2);

    // Giant frame followed by a good frame
    clear_cnt();
    b0 = out_beats; build(MAC, 1600); send_frame(0, 0, 0, -1); settle();
    chk("giant_beats", 64'(out_beats - b0), 64'd1523);
    chk("giant_user", 64'(last_user), 64'd1);
    chk("giant_cnt_err", 64'(cnt_err), 64'd1);
    b0 = out_beats; build(MAC, 64); send_frame(0, 0, 0, -1); settle();
    chk("post_giant_beats", 64'(out_beats - b0), 64'd64);
    chk("post_giant_ok", 64'(cnt_ok), 64'd1);

    // Enable control
    clear_cnt();
    rx_enable = 1'b0;
    b0 = out_beats; build(MAC, 64); send_frame(0, 0, 0, -1); settle();
    chk("dis_beats", 64'(out_beats - b0), 64'd0);
    chk("dis_cnt_filt", 64'(cnt_filt), 64'd1);
    rx_enable = 1'b1;
    b0 = out_beats; build(MAC, 64); send_frame(0, 1, 0, -1); settle();
    chk("en_fall_beats", 64'(out_beats - b0), 64'd64);
    chk("en_fall_ok", 64'(cnt_ok), 64'd1);
    rx_enable = 1'b1;

    // Counter saturation and clear-vs-increment priority
    clear_cnt();
    for (int k = 0; k < 5; k++) begin
      build(MAC, 64); send_frame(1, 0, 0, -1);
    end
    settle();
    chk("sat_cnt_ok", 64'(cnt_ok), 64'd3);
    build(MAC, 64); send_frame(0, 0, 1, -1); settle();
    chk("clr_last_ok", 64'(cnt_ok), 64'd0);

    // Reset in the middle of a frame; remainder becomes a runt
    build(MAC, 64); send_frame(0, 0, 0, -1);
    build(MAC, 64);
    rest_b = fb[20:$];
    rest_u = fu[20:$];
    send_frame(0, 0, 0, 20);
    chk("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    chk("pre_rst_ok", 64'(cnt_ok), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_last", 64'(m_axis_tlast), 64'd0);
    chk("mid_rst_data", 64'(m_axis_tdata), 64'd0);
    chk("mid_rst_ok", 64'(cnt_ok), 64'd0);
    #2 rst = 1'b0;
    fb = rest_b;
    fu = rest_u;
    b0 = out_beats; send_frame(0, 0, 0, -1); settle();
    chk("rest_beats", 64'(out_beats - b0), 64'd44);
    chk("rest_cnt_err", 64'(cnt_err), 64'd1);

    // Randomized traffic
    for (int f = 0; f < 60; f++) begin
      int len, sel, k;
      promisc      = ($urandom_range(0, 4) == 0);
      accept_bcast = 1'($urandom);
      accept_mcast = 1'($urandom);
      rx_enable    = ($urandom_range(0, 5) != 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1: da = MAC;
        2:    da = 48'hFFFF_FFFF_FFFF;
        3:    begin da = {$urandom(), 16'($urandom())}; da[40] = 1'b1; end
        4:    begin da = {$urandom(), 16'($urandom())}; da[40] = 1'b0; end
        default: begin
          da = MAC; k = $urandom_range(0, 5);
          da[8*k +: 8] = da[8*k +: 8] ^ 8'h10;
        end
      endcase
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(1, 8);
        1:       len = $urandom_range(60, 68);
        default: len = $urandom_range(64, 300);
      endcase
      build(da, len);
      if ($urandom_range(0, 3) == 0) fu[$urandom_range(0, len - 1)] = 1'b1;
      if ($urandom_range(0, 2) == 0) idle(1'b1);
      repeat ($urandom_range(0, 2)) idle(1'b0);
      send_frame(1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), -1);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_rx_frame_ctrl.md
# eth_rx_frame_ctrl

Receive-side admission controller between the GMII frame receiver's AXI stream output and the drop-capable RX packet FIFO. It tracks each frame from first beat to `tlast` and checks the destination MAC address, frame length and receiver error flags. On the final beat it signals commit or drop to the FIFO via `m_axis_tuser`, and it maintains saturating per-class frame counters. It also implements receiver enable/disable on frame boundaries.

## Interface
- `MIN_LEN`, 64: minimum frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, 1522: maximum frame length in bytes, DA through FCS inclusive.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `s_axis_tdata` in 8: frame bytes, DA first, FCS last.
- `s_axis_tvalid` in 1: beat valid; gaps are allowed inside a frame; no backpressure.
- `s_axis_tlast` in 1: last byte of the frame.
- `s_axis_tuser` in 1: receive error; may assert on any beat of a frame.
- `m_axis_tdata` out 8: forwarded byte.
- `m_axis_tvalid` out 1: forwarded beat valid.
- `m_axis_tlast` out 1: forwarded last beat.
- `m_axis_tuser` out 1: drop verdict; meaningful only with `m_axis_tlast`.
- `rx_enable` in 1: receiver enable; sampled at frame start only.
- `promisc` in 1: accept any destination address.
- `accept_bcast` in 1: accept DA FF:FF:FF:FF:FF:FF.
- `accept_mcast` in 1: accept DA with byte0 bit0 = 1.
- `mac_addr` in 48: station address; byte0 of DA compares to `mac_addr[47:40]`.
- `cnt_clear` in 1: synchronous clear of all counters.
- `cnt_ok`, `cnt_err`, `cnt_filt` out CNT_W: accepted, errored, and filtered frame counts.

## Operation
- FSM states: IDLE, ACTIVE, DISCARD.
- IDLE + valid beat with `rx_enable`=1 → ACTIVE:
  - Byte count = 1; beat is forwarded.
  - Error flag and address-match tracking start from this beat.
- IDLE + valid beat with `rx_enable`=0 → DISCARD; the frame is marked filtered and nothing is forwarded.
- ACTIVE:
  - Every valid input beat is forwarded.
  - Byte counter is 16 bits and saturates at 0xFFFF.
  - Error flag = OR of `s_axis_tuser` over all beats of the frame.
  - DA bytes 0..5 are compared to `mac_addr`. In parallel, broadcast is detected (all bytes FF) and multicast is detected (byte0 bit0).
- Address accept = `promisc` | unicast match | (`accept_bcast` & bcast) | (`accept_mcast` & mcast & !bcast).
- ACTIVE + input `tlast` → IDLE. Verdict:
  - err if error flag, or length < `MIN_LEN` (this includes frames shorter than 6 bytes);
  - else filt if address not accepted;
  - else ok.
- Final forwarded beat: `m_axis_tuser` = (verdict ≠ ok).
- Giant: the beat that makes count = `MAX_LEN`+1 without `tlast`:
  - That beat is forwarded with `m_axis_tlast`=1 and `m_axis_tuser`=1; verdict err.
  - FSM → DISCARD, swallowing input until `tlast`.
- DISCARD: no output. Input `tlast` → IDLE. Counters are not touched on exit; the count happened at entry (filtered or giant).
- `rx_enable` changes mid-frame have no effect on the current frame.
- Counters:
  - Exactly one counter increments per frame, saturating at all ones.
  - `cnt_clear` wins over a simultaneous increment; that event is lost.
- Beats with `s_axis_tvalid`=0 change no state.

## Timing
- Output is registered: forwarded beat appears 1 cycle after the input beat, with data, last and user aligned.
- `m_axis_tvalid` is low whenever no beat is forwarded.
- Counters update in the same cycle as the final forwarded beat. For DISCARD-at-start frames they update 1 cycle after the first input beat.
- Back-to-back frames are supported: a first beat in the cycle after `tlast` is handled as a new frame with no bubble.
- Reset: state IDLE.
  - All `m_axis_*` 0.
  - All counters 0.
  - Internal flags cleared.
- Reset asserted mid-frame:
  - Output drops immediately with no `tlast`.
  - The remainder of that frame is treated as a new frame at its next valid beat.

## Test plan
- Unicast good frame: 64 bytes with DA = `mac_addr` = 02:00:00:00:00:01, no tuser. Expect 64 output beats at 1-cycle latency, last beat tuser=0, `cnt_ok`=1.
- Broadcast frame: 100 bytes with `promisc`=0, `accept_bcast`=0. Expect 100 beats, last tuser=1, `cnt_filt`=1. Repeat with `accept_bcast`=1: expect last tuser=0, `cnt_ok`=1.
- Error and runt:
  - 80-byte frame with `s_axis_tuser`=1 on beat 40 only: last tuser=1, `cnt_err`=1.
  - 60-byte clean frame: last tuser=1, `cnt_err`=2.
- Giant: 1600-byte frame with `MAX_LEN`=1522. Expect exactly 1523 output beats, beat 1523 with tlast=1 and tuser=1, then silence. `cnt_err`=1. A following 64-byte good frame passes normally.
- Enable control:
  - `rx_enable`=0 at the first beat of a 64-byte frame: zero output beats, `cnt_filt`=1.
  - `rx_enable` falling at byte 10 of an accepted frame: full frame forwarded, `cnt_ok`=1.
- Counter edges:
  - With `CNT_W`=2, send 5 good frames: `cnt_ok` saturates at 3.
  - `cnt_clear` in the same cycle as a final beat: counter = 0 afterward.
  - Reset mid-frame: all outputs 0 within the reset cycle.
